// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared state encoding and parameter limits for the sequence detector
package seq_det_pkg;

  // Detector states: no pattern loaded, searching, and one-cycle match report.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HUNT  = 2'd1,
    ST_MATCH = 2'd2
  } det_state_e;

  // Legal ranges for the pattern length and the match counter width.
  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;
  localparam int CNT_W_MIN = 2;
  localparam int CNT_W_MAX = 16;

endpackage

// File: rtl/seq_detector_fsm_if.sv
// rtl/seq_detector_fsm_if.sv - configuration, stream and status signals of the sequence detector
interface seq_detector_fsm_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);

  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic             cfg_overlap;
  logic             clr_count;
  logic             in_valid;
  logic             inp;
  logic             z;
  logic             armed;
  logic [CNT_W-1:0] match_count;
  logic             count_ovf;

  // Driver side: configures the detector, feeds the stream, observes status.
  modport master (
    output cfg_load, cfg_pattern, cfg_overlap, clr_count, in_valid, inp,
    input  z, armed, match_count, count_ovf
  );

  // Detector side.
  modport slave (
    input  cfg_load, cfg_pattern, cfg_overlap, clr_count, in_valid, inp,
    output z, armed, match_count, count_ovf
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with sticky overflow flag
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  logic [WIDTH-1:0] count_q;
  logic             ovf_q;

  // Clear wins over increment; an increment while saturated only raises the flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clr) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (inc) begin
      if (count_q == {WIDTH{1'b1}}) begin
        ovf_q <= 1'b1;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/seq_detector_fsm.sv
// rtl/seq_detector_fsm.sv - serial pattern detector with overlap mode and saturating match counter
module seq_detector_fsm
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                reset,
  seq_detector_fsm_if.slave  bus
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("seq_detector_fsm: PAT_W out of range");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("seq_detector_fsm: CNT_W out of range");
  end

  det_state_e        state_q, state_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              ovl_q, ovl_d;

  logic [PAT_W-1:0]  hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              match;

  // State, history, fill and latched configuration; reset abandons everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
    end
  end

  // Next state: a load always restarts the hunt; otherwise accepted bits shift in and are compared.
  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    pat_d      = pat_q;
    ovl_d      = ovl_q;
    match      = 1'b0;
    hist_shift = {hist_q[PAT_W-2:0], bus.inp};
    fill_inc   = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + 1'b1;

    if (bus.cfg_load) begin
      // The bit presented alongside a load is deliberately dropped.
      pat_d   = bus.cfg_pattern;
      ovl_d   = bus.cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      state_d = ST_HUNT;
    end else begin
      case (state_q)
        ST_HUNT, ST_MATCH: begin
          state_d = ST_HUNT;
          if (bus.in_valid) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if (fill_inc == FILL_W'(PAT_W) && hist_shift == pat_q) begin
              match   = 1'b1;
              state_d = ST_MATCH;
              // Non-overlapping mode needs a full fresh pattern for the next hit.
              if (!ovl_q) begin
                fill_d = '0;
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .clr   (bus.clr_count),
    .count (bus.match_count),
    .ovf   (bus.count_ovf)
  );

  assign bus.z     = (state_q == ST_MATCH);
  assign bus.armed = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_detector_fsm.sv
// tb/tb_seq_detector_fsm.sv - directed and randomized checks of seq_detector_fsm against a behavioural model
module tb_seq_detector_fsm;

  localparam int P = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  seq_detector_fsm_if #(.PAT_W(P), .CNT_W(8)) bus8 ();
  seq_detector_fsm_if #(.PAT_W(P), .CNT_W(2)) bus2 ();

  seq_detector_fsm #(.PAT_W(P), .CNT_W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));
  seq_detector_fsm #(.PAT_W(P), .CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic         d_load = 0, d_ovl = 0, d_clr = 0, d_v = 0, d_b = 0;
  logic [P-1:0] d_pat = '0;

  int m_armed, m_z, m_pat, m_ovl, m_hist, m_fill, m_cnt8, m_ovf8, m_cnt2, m_ovf2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus8.cfg_load = d_load; bus8.cfg_pattern = d_pat; bus8.cfg_overlap = d_ovl;
    bus8.clr_count = d_clr; bus8.in_valid = d_v; bus8.inp = d_b;
    bus2.cfg_load = d_load; bus2.cfg_pattern = d_pat; bus2.cfg_overlap = d_ovl;
    bus2.clr_count = d_clr; bus2.in_valid = d_v; bus2.inp = d_b;
  endtask

  task automatic model_reset();
    m_armed = 0; m_z = 0; m_pat = 0; m_ovl = 0; m_hist = 0; m_fill = 0;
    m_cnt8 = 0; m_ovf8 = 0; m_cnt2 = 0; m_ovf2 = 0;
  endtask

  // Behavioural model: history as an integer of the last P bits, fill as bits seen since restart.
  task automatic model_step();
    int hit;
    hit = 0;
    if (d_load) begin
      m_pat = int'(d_pat); m_ovl = int'(d_ovl);
      m_hist = 0; m_fill = 0; m_armed = 1; m_z = 0;
    end else if (m_armed == 1 && d_v) begin
      m_hist = (m_hist * 2 + int'(d_b)) % (1 << P);
      if (m_fill < P) m_fill++;
      hit = (m_fill == P && m_hist == m_pat) ? 1 : 0;
      m_z = hit;
      if (hit == 1 && m_ovl == 0) m_fill = 0;
    end else begin
      m_z = 0;
    end
    if (d_clr) begin
      m_cnt8 = 0; m_ovf8 = 0; m_cnt2 = 0; m_ovf2 = 0;
    end else if (hit == 1) begin
      if (m_cnt8 == 255) m_ovf8 = 1; else m_cnt8++;
      if (m_cnt2 == 3) m_ovf2 = 1; else m_cnt2++;
    end
  endtask

  task automatic check_all();
    chk("z",      bus8.z,           m_z);
    chk("armed",  bus8.armed,       m_armed);
    chk("count8", bus8.match_count, m_cnt8);
    chk("ovf8",   bus8.count_ovf,   m_ovf8);
    chk("z2",     bus2.z,           m_z);
    chk("count2", bus2.match_count, m_cnt2);
    chk("ovf2",   bus2.count_ovf,   m_ovf2);
  endtask

  task automatic cycle();
    apply();
    @(posedge clk);
    #1;
    model_step();
    check_all();
  endtask

  task automatic bit_in(input logic b);
    d_load = 0; d_clr = 0; d_v = 1; d_b = b;
    cycle();
  endtask

  task automatic idle();
    d_load = 0; d_clr = 0; d_v = 0; d_b = $urandom_range(0, 1);
    cycle();
  endtask

  task automatic load(input logic [P-1:0] pat, input logic ovl);
    d_load = 1; d_pat = pat; d_ovl = ovl; d_clr = 0; d_v = 0;
    cycle();
    d_load = 0;
  endtask

  task automatic clear_count();
    d_load = 0; d_clr = 1; d_v = 0;
    cycle();
    d_clr = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
  endtask

  logic [6:0] stream7;
  logic [6:0] zb;
  int         r;
  int         cnt_before;

  initial begin
    model_reset();
    apply();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // Overlapping detection of 1011 in 1011011.
    stream7 = 7'b1011011;
    load(4'b1011, 1'b1);
    zb = '0;
    for (int i = 6; i >= 0; i--) begin
      bit_in(stream7[i]);
      zb = {zb[5:0], bus8.z};
    end
    chk("ovl_z_pulses", zb, 7'b0001001);
    chk("ovl_count", bus8.match_count, 2);
    idle();
    clear_count();

    // Same stream, non-overlapping.
    load(4'b1011, 1'b0);
    zb = '0;
    for (int i = 6; i >= 0; i--) begin
      bit_in(stream7[i]);
      zb = {zb[5:0], bus8.z};
    end
    chk("novl_z_pulses", zb, 7'b0001000);
    chk("novl_count", bus8.match_count, 1);
    idle();

    // Gaps of three idle cycles between valid bits.
    load(4'b1011, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      bit_in(stream7[i + 3]);
      if (i == 0) chk("gap_z", bus8.z, 1);
      else chk("gap_noz", bus8.z, 0);
      if (i != 0) begin
        idle(); idle(); idle();
      end
    end
    idle();
    chk("gap_z_done", bus8.z, 0);

    // Saturation of the narrow counter: 1111 overlapping over nine ones gives six matches.
    clear_count();
    load(4'b1111, 1'b1);
    for (int i = 0; i < 9; i++) bit_in(1'b1);
    chk("sat_count2", bus2.match_count, 3);
    chk("sat_ovf2", bus2.count_ovf, 1);
    chk("sat_count8", bus8.match_count, 6);
    clear_count();
    chk("clr_count2", bus2.match_count, 0);
    chk("clr_ovf2", bus2.count_ovf, 0);

    // Reset mid-stream abandons the partial match.
    load(4'b1011, 1'b1);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    do_reset();
    chk("rst_armed", bus8.armed, 0);
    bit_in(1'b1);
    chk("rst_noz", bus8.z, 0);
    load(4'b1011, 1'b1);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    chk("rst_reload_z", bus8.z, 1);
    idle();

    // Load colliding with a valid bit that would have completed the old pattern.
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    cnt_before = int'(bus8.match_count);
    d_load = 1; d_pat = 4'b0110; d_ovl = 1; d_v = 1; d_b = 1; d_clr = 0;
    cycle();
    d_load = 0;
    chk("coll_noz", bus8.z, 0);
    chk("coll_count_kept", bus8.match_count, cnt_before);
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
    chk("coll_new_z", bus8.z, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        do_reset();
      end else if (r < 4) begin
        d_load = 1; d_pat = P'($urandom_range(0, 15)); d_ovl = 1'($urandom_range(0, 1));
        d_clr = 1'($urandom_range(0, 99) < 10);
        d_v = 1'($urandom_range(0, 1)); d_b = 1'($urandom_range(0, 1));
        cycle();
        d_load = 0;
      end else begin
        d_load = 0;
        d_clr = 1'($urandom_range(0, 99) < 3);
        d_v = 1'($urandom_range(0, 99) < 65);
        d_b = 1'($urandom_range(0, 1));
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
